// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   state_t   : memory-wait FSM states (RUN, MEM_WAIT)
//   fwd_sel_t : per-source operand forwarding select
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF    = 2'b00;  // register file value
    localparam fwd_sel_t FWD_EXMEM = 2'b01;  // EXE/MEM ALU result
    localparam fwd_sel_t FWD_MEMWB = 2'b10;  // MEM/WB write-back value

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// fwd_unit: forwarding select for a single EXE source operand.
//   rs, rs_used             : source register and its "operand read" flag
//   exmem_dest/_wb_en/_rd_mem : producer in MEM
//   memwb_dest/_wb_en       : producer in WB
//   sel                     : FWD_RF / FWD_EXMEM / FWD_MEMWB
// The younger producer (MEM) wins; a load in MEM has no data yet, so it is
// never forwarded from EXE/MEM.
module fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 3
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              rs_used,
    input  logic [REG_AW-1:0] exmem_dest,
    input  logic              exmem_wb_en,
    input  logic              exmem_rd_mem,
    input  logic [REG_AW-1:0] memwb_dest,
    input  logic              memwb_wb_en,
    output logic [1:0]        sel
);

    always_comb begin
        sel = FWD_RF;
        if (rs_used) begin
            if (exmem_wb_en && !exmem_rd_mem && (exmem_dest == rs)) begin
                sel = FWD_EXMEM;
            end else if (memwb_wb_en && (memwb_dest == rs)) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central control for the 5-stage IF/ID/EXE/MEM/WB pipeline.
//   Inputs : per-stage register addresses / controls, branch_taken, mem_ack,
//            cnt_clr, synchronous active-high rst.
//   Outputs: stage advance enables (pc/ifid/idexe/exmem/memwb), bubble
//            inserts (ifid_flush/idexe_flush), per-source fwd_sel, sticky
//            mem_err timeout flag, saturating stall/flush event counters.
// Priority of pipeline actions: reset > memory freeze > branch > load-use.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 3,
    parameter int NSRC    = 3,
    parameter int CNT_W   = 16,
    parameter int MEM_TMO = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NSRC*REG_AW-1:0] id_rs,
    input  logic [NSRC-1:0]        id_rs_used,
    input  logic [NSRC*REG_AW-1:0] ex_rs,
    input  logic [NSRC-1:0]        ex_rs_used,
    input  logic [REG_AW-1:0]      idex_dest,
    input  logic                   idex_wb_en,
    input  logic                   idex_rd_mem,
    input  logic [REG_AW-1:0]      exmem_dest,
    input  logic                   exmem_wb_en,
    input  logic                   exmem_rd_mem,
    input  logic                   exmem_wr_mem,
    input  logic [REG_AW-1:0]      memwb_dest,
    input  logic                   memwb_wb_en,
    input  logic                   branch_taken,
    input  logic                   mem_ack,
    input  logic                   cnt_clr,
    output logic                   pc_enable,
    output logic                   ifid_en,
    output logic                   idexe_en,
    output logic                   exmem_en,
    output logic                   memwb_en,
    output logic                   ifid_flush,
    output logic                   idexe_flush,
    output logic [2*NSRC-1:0]      fwd_sel,
    output logic                   mem_err,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       flush_cnt
);

    localparam int                WAIT_W   = $clog2(MEM_TMO);
    localparam logic [WAIT_W-1:0] TMO_LAST = WAIT_W'(MEM_TMO - 1);

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               mem_err_q, mem_err_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic               mem_acc;
    logic               freeze;
    logic               load_use;
    logic [2*NSRC-1:0]  fwd_raw;

    // ---------------- forwarding, one unit per source ----------------
    for (genvar k = 0; k < NSRC; k++) begin : g_fwd
        fwd_unit #(.REG_AW(REG_AW)) u_fwd (
            .rs          (ex_rs[k*REG_AW +: REG_AW]),
            .rs_used     (ex_rs_used[k]),
            .exmem_dest  (exmem_dest),
            .exmem_wb_en (exmem_wb_en),
            .exmem_rd_mem(exmem_rd_mem),
            .memwb_dest  (memwb_dest),
            .memwb_wb_en (memwb_wb_en),
            .sel         (fwd_raw[2*k +: 2])
        );
    end

    // ---------------- hazard detection ----------------
    always_comb begin
        load_use = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (id_rs_used[k] && (id_rs[k*REG_AW +: REG_AW] == idex_dest)) begin
                load_use = 1'b1;
            end
        end
        load_use = load_use && idex_rd_mem && idex_wb_en;
    end

    assign mem_acc = exmem_rd_mem | exmem_wr_mem;
    // An ack in the same cycle releases immediately, so no freeze then.
    assign freeze  = !mem_ack && ((state_q == MEM_WAIT) || mem_acc);

    // ---------------- stage controls ----------------
    always_comb begin
        pc_enable   = 1'b1;
        ifid_en     = 1'b1;
        idexe_en    = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idexe_flush = 1'b0;
        fwd_sel     = fwd_raw;
        if (rst) begin
            {pc_enable, ifid_en, idexe_en, exmem_en, memwb_en} = '0;
            ifid_flush  = 1'b1;
            idexe_flush = 1'b1;
            fwd_sel     = '0;
        end else if (freeze) begin
            // Stages hold, so branch/load-use are re-evaluated on release.
            {pc_enable, ifid_en, idexe_en, exmem_en, memwb_en} = '0;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idexe_flush = 1'b1;
        end else if (load_use) begin
            pc_enable   = 1'b0;
            ifid_en     = 1'b0;
            idexe_flush = 1'b1;
        end
    end

    // ---------------- memory wait FSM + counters ----------------
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        mem_err_d   = mem_err_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        case (state_q)
            RUN: begin
                if (mem_acc && !mem_ack) begin
                    state_d = MEM_WAIT;
                    wait_d  = '0;
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else if (wait_q == TMO_LAST) begin
                    state_d   = RUN;
                    wait_d    = '0;
                    mem_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if ((freeze || (!branch_taken && load_use)) && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (!freeze && branch_taken && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_q      <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed + randomized checks of hazard_ctrl against a
// rule-level reference model held in this bench.
module tb_hazard_ctrl;

    localparam int RA  = 3;
    localparam int NS  = 3;
    localparam int CW  = 4;
    localparam int TMO = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [NS*RA-1:0] id_rs, ex_rs;
    logic [NS-1:0]    id_rs_used, ex_rs_used;
    logic [RA-1:0]    idex_dest, exmem_dest, memwb_dest;
    logic idex_wb_en, idex_rd_mem, exmem_wb_en, exmem_rd_mem, exmem_wr_mem;
    logic memwb_wb_en, branch_taken, mem_ack, cnt_clr;
    logic pc_enable, ifid_en, idexe_en, exmem_en, memwb_en, ifid_flush, idexe_flush;
    logic [2*NS-1:0] fwd_sel;
    logic mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.REG_AW(RA), .NSRC(NS), .CNT_W(CW), .MEM_TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rs_used(id_rs_used),
        .ex_rs(ex_rs), .ex_rs_used(ex_rs_used),
        .idex_dest(idex_dest), .idex_wb_en(idex_wb_en), .idex_rd_mem(idex_rd_mem),
        .exmem_dest(exmem_dest), .exmem_wb_en(exmem_wb_en),
        .exmem_rd_mem(exmem_rd_mem), .exmem_wr_mem(exmem_wr_mem),
        .memwb_dest(memwb_dest), .memwb_wb_en(memwb_wb_en),
        .branch_taken(branch_taken), .mem_ack(mem_ack), .cnt_clr(cnt_clr),
        .pc_enable(pc_enable), .ifid_en(ifid_en), .idexe_en(idexe_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idexe_flush(idexe_flush),
        .fwd_sel(fwd_sel), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: "waiting" flag plus number of cycles spent waiting.
    bit m_wait;
    int m_waited;
    bit m_err;
    int m_stall, m_flush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit hazard_now();
        bit h = 1'b0;
        for (int k = 0; k < NS; k++)
            if (id_rs_used[k] && id_rs[k*RA +: RA] == idex_dest) h = 1'b1;
        return h && idex_rd_mem && idex_wb_en;
    endfunction

    function automatic logic [2*NS-1:0] fwd_expect();
        logic [2*NS-1:0] f = '0;
        for (int k = 0; k < NS; k++) begin
            if (ex_rs_used[k]) begin
                if (exmem_wb_en && !exmem_rd_mem && exmem_dest == ex_rs[k*RA +: RA])
                    f[2*k +: 2] = 2'd1;
                else if (memwb_wb_en && memwb_dest == ex_rs[k*RA +: RA])
                    f[2*k +: 2] = 2'd2;
            end
        end
        return f;
    endfunction

    // One clock: check all outputs against the model, clock, advance model.
    task automatic cycle();
        logic [6:0] e;
        logic [6:0] ctl;
        bit acc, frz, hz;
        #2;
        acc = exmem_rd_mem || exmem_wr_mem;
        frz = !mem_ack && (m_wait || acc);
        hz  = hazard_now();
        if (rst)               e = 7'b0000011;
        else if (frz)          e = 7'b0000000;
        else if (branch_taken) e = 7'b1111111;
        else if (hz)           e = 7'b0011101;
        else                   e = 7'b1111100;
        ctl = {pc_enable, ifid_en, idexe_en, exmem_en, memwb_en, ifid_flush, idexe_flush};
        chk("ctl", 32'(ctl), 32'(e));
        chk("fwd_sel", 32'(fwd_sel), rst ? 32'd0 : 32'(fwd_expect()));
        chk("mem_err", 32'(mem_err), 32'(m_err));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        @(posedge clk);
        if (rst) begin
            m_wait = 0; m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (cnt_clr) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if ((frz || (!branch_taken && hz)) && m_stall < CMAX) m_stall++;
                if (!frz && branch_taken && m_flush < CMAX) m_flush++;
            end
            if (m_wait) begin
                if (mem_ack) m_wait = 0;
                else begin
                    m_waited++;
                    if (m_waited == TMO) begin m_wait = 0; m_err = 1; end
                end
            end else if (acc && !mem_ack) begin
                m_wait = 1; m_waited = 0;
            end
        end
        #1;
    endtask

    task automatic idle();
        rst = 0; id_rs = '0; id_rs_used = '0; ex_rs = '0; ex_rs_used = '0;
        idex_dest = '0; idex_wb_en = 0; idex_rd_mem = 0;
        exmem_dest = '0; exmem_wb_en = 0; exmem_rd_mem = 0; exmem_wr_mem = 0;
        memwb_dest = '0; memwb_wb_en = 0; branch_taken = 0; mem_ack = 0; cnt_clr = 0;
    endtask

    task automatic set_load_use();
        idex_rd_mem = 1; idex_wb_en = 1; idex_dest = 3'd3;
        id_rs = '0; id_rs[1*RA +: RA] = 3'd3; id_rs_used = 3'b010;
    endtask

    initial begin
        idle();
        rst = 1; exmem_rd_mem = 1;
        @(posedge clk); #1;
        m_wait = 0; m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0;

        // Reset holds outputs regardless of a pending access
        #1 chk("rst_ctl_flush", 32'({ifid_flush, idexe_flush, pc_enable}), 32'b110);
        cycle();
        idle(); cycle();

        // Load-use: exactly one bubble
        set_load_use();
        #1 chk("lu_pc_en", 32'(pc_enable), 32'd0);
        cycle();
        idex_rd_mem = 0;
        #1 chk("lu_release_pc_en", 32'(pc_enable), 32'd1);
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        cycle();

        // Double forward
        idle();
        ex_rs[0 +: RA] = 3'd5; ex_rs_used = 3'b001;
        exmem_dest = 3'd5; exmem_wb_en = 1; memwb_dest = 3'd5; memwb_wb_en = 1;
        #1 chk("fwd_exmem", 32'(fwd_sel[1:0]), 32'd1);
        cycle();
        exmem_rd_mem = 1; mem_ack = 1;
        #1 chk("fwd_load_memwb", 32'(fwd_sel[1:0]), 32'd2);
        cycle();
        ex_rs_used = 3'b000;
        #1 chk("fwd_unused", 32'(fwd_sel[1:0]), 32'd0);
        cycle();

        // Branch overrides load-use
        idle(); cnt_clr = 1; cycle(); cnt_clr = 0;
        set_load_use(); branch_taken = 1;
        #1 chk("br_ctl", 32'({pc_enable, ifid_flush, idexe_flush}), 32'b111);
        cycle();
        idle();
        chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("br_stall_cnt", 32'(stall_cnt), 32'd0);
        cycle();

        // Memory wait 4 cycles with branch held
        cnt_clr = 1; cycle(); cnt_clr = 0;
        exmem_rd_mem = 1; branch_taken = 1; mem_ack = 0;
        repeat (4) begin
            #1 chk("mw_frozen", 32'({pc_enable, memwb_en, ifid_flush}), 32'd0);
            cycle();
        end
        mem_ack = 1;
        #1 chk("mw_release", 32'({pc_enable, ifid_flush, idexe_flush}), 32'b111);
        cycle();
        idle();
        chk("mw_stall_cnt", 32'(stall_cnt), 32'd4);
        chk("mw_flush_cnt", 32'(flush_cnt), 32'd1);
        cycle();

        // Timeout
        exmem_rd_mem = 1; cycle(); exmem_rd_mem = 0;
        repeat (7) cycle();
        chk("tmo_err_early", 32'(mem_err), 32'd0);
        cycle();
        chk("tmo_err_set", 32'(mem_err), 32'd1);
        #1 chk("tmo_run", 32'(pc_enable), 32'd1);
        cycle();
        repeat (3) cycle();
        chk("tmo_err_sticky", 32'(mem_err), 32'd1);

        // Reset mid-wait
        exmem_rd_mem = 1; cycle(); exmem_rd_mem = 0; cycle();
        rst = 1;
        #1 chk("rst_wait_ctl", 32'({pc_enable, ifid_flush, idexe_flush}), 32'b011);
        cycle(); rst = 0;
        chk("rst_wait_err", 32'(mem_err), 32'd0);
        chk("rst_wait_stall", 32'(stall_cnt), 32'd0);
        #1 chk("rst_wait_run", 32'(pc_enable), 32'd1);
        cycle();

        // Saturation and clear-over-increment
        set_load_use();
        repeat (20) cycle();
        chk("sat_stall", 32'(stall_cnt), 32'd15);
        cnt_clr = 1; cycle(); cnt_clr = 0;
        chk("clr_stall", 32'(stall_cnt), 32'd0);
        idle(); cycle();

        // Randomized against the model
        for (int i = 0; i < 600; i++) begin
            rst          = ($urandom_range(0, 79) == 0);
            cnt_clr      = ($urandom_range(0, 29) == 0);
            id_rs        = (NS*RA)'($urandom);
            ex_rs        = (NS*RA)'($urandom);
            id_rs_used   = NS'($urandom);
            ex_rs_used   = NS'($urandom);
            idex_dest    = RA'($urandom);
            exmem_dest   = RA'($urandom);
            memwb_dest   = RA'($urandom);
            idex_wb_en   = 1'($urandom);
            idex_rd_mem  = 1'($urandom);
            exmem_wb_en  = 1'($urandom);
            memwb_wb_en  = 1'($urandom);
            exmem_rd_mem = ($urandom_range(0, 5) == 0);
            exmem_wr_mem = ($urandom_range(0, 7) == 0);
            branch_taken = ($urandom_range(0, 5) == 0);
            mem_ack      = (i < 300) ? 1'($urandom) : ($urandom_range(0, 11) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central pipeline control for the 5-stage IF/ID/EXE/MEM/WB core, generalised over register-file size and source-operand count. It detects load-use hazards, selects operand forwarding for each EXE source, and flushes IF/ID and ID/EXE on a taken branch. It also freezes the whole pipeline while a multi-cycle data memory access is outstanding. Stall and flush event counters are included. It sits beside the pipe registers and drives their enable/flush inputs and the PC enable.

Parameters:
REG_AW, 3, register address width (2**REG_AW registers; no hardwired zero register)
NSRC, 3, source operands per instruction
CNT_W, 16, width of performance counters
MEM_TMO, 64, max cycles in MEM_WAIT before timeout (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_rs  in  NSRC*REG_AW  source regs of instruction in ID (src k at [k*REG_AW +: REG_AW])
id_rs_used  in  NSRC  per-source "operand read" flags, ID
ex_rs  in  NSRC*REG_AW  source regs of instruction in EXE
ex_rs_used  in  NSRC  per-source flags, EXE
idex_dest  in  REG_AW  dest of instruction in EXE
idex_wb_en, idex_rd_mem  in  1  EXE instruction writes back / is a load
exmem_dest  in  REG_AW  dest in MEM
exmem_wb_en, exmem_rd_mem, exmem_wr_mem  in  1  MEM-stage controls
memwb_dest  in  REG_AW  dest in WB
memwb_wb_en  in  1  WB writes back
branch_taken  in  1  from EXE
mem_ack  in  1  data memory completed access this cycle
cnt_clr  in  1  synchronous clear of counters
pc_enable, ifid_en, idexe_en, exmem_en, memwb_en  out  1  stage advance enables
ifid_flush, idexe_flush  out  1  insert bubble
fwd_sel  out  2*NSRC  per-source select: 00 regfile, 01 EXE/MEM alu result, 10 MEM/WB wb value
mem_err  out  1  sticky timeout flag
stall_cnt, flush_cnt  out  CNT_W  event counters

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high on clk/rst. rst high at a clock edge sets state=RUN, wait counter=0, mem_err=0, and both counters=0.
- While rst is high: all enables=0, both flushes=1, fwd_sel=0. This holds regardless of state, including mid-MEM_WAIT.
- FSM states: RUN and MEM_WAIT.
  - RUN -> MEM_WAIT when (exmem_rd_mem|exmem_wr_mem) & !mem_ack.
  - MEM_WAIT -> RUN on mem_ack, or when the wait counter reaches MEM_TMO-1. On timeout, set mem_err=1 (sticky until rst).
  - An ack in the same cycle the access appears causes no wait.
- Freeze: all five enables=0 and both flushes=0 when either:
  - state=MEM_WAIT and !mem_ack, or
  - state=RUN with a memory access present and !mem_ack.
  Freeze has top priority. A branch_taken or load-use during a freeze is not acted on; it is evaluated again when the freeze releases, because the stages hold their contents.
- Branch, when not frozen: branch_taken=1 gives ifid_flush=1, idexe_flush=1, all enables=1. Branch overrides load-use in the same cycle.
- Load-use, when not frozen and no branch: stall if idex_rd_mem & idex_wb_en & there is some k with id_rs_used[k] & id_rs[k]==idex_dest. Stall drives:
  - pc_enable=0, ifid_en=0
  - idexe_flush=1
  - idexe_en=exmem_en=memwb_en=1
  Exactly one bubble per hazard.
- Forwarding, combinational per k, only when ex_rs_used[k] (else 00):
  - 01 if exmem_wb_en & !exmem_rd_mem & exmem_dest==ex_rs[k];
  - else 10 if memwb_wb_en & memwb_dest==ex_rs[k];
  - else 00.
  - The younger stage wins. Loads in MEM are never forwarded from EXE/MEM.
- Normal operation: all enables=1, flushes=0.
- Counters:
  - stall_cnt increments in each cycle with a freeze or load-use stall.
  - flush_cnt increments in each cycle a branch flush is issued.
  - Both saturate at all-ones.
  - cnt_clr zeroes them, with priority over increment.

Decomposition:
- Package hazard_pkg holds:
  - typedef state_t {RUN, MEM_WAIT};
  - fwd_sel_t constants FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
- Sub-module fwd_unit: one instance per source via generate; purely the priority compare. The FSM, stall/flush logic and counters stay in hazard_ctrl.

Test Plan:
- Load-use: idex_rd_mem=1, idex_wb_en=1, idex_dest=3; id_rs src1=3, used -> exactly one cycle of pc_enable=0, ifid_en=0, idexe_flush=1; stall_cnt goes 0->1.
- Double forward: ex_rs src0=5, exmem_dest=5 (ALU op), memwb_dest=5 -> fwd_sel[1:0]=01. Same case with exmem_rd_mem=1 -> fwd_sel[1:0]=10. Same case with ex_rs_used[0]=0 -> 00.
- Branch during load-use: branch_taken=1 with hazard condition true -> ifid_flush=idexe_flush=1, pc_enable=1; flush_cnt=1, stall_cnt unchanged.
- Memory wait: exmem_rd_mem=1, mem_ack low 4 cycles then high -> enables 0 for 4 cycles, state returns to RUN after the ack cycle; stall_cnt=4. branch_taken held high during the wait -> flush issued only after release.
- Timeout: MEM_TMO=8, mem_ack never asserted -> mem_err=1 after 8 wait cycles, state=RUN, mem_err remains 1 until rst.
- Reset mid-wait plus saturation: rst pulse during MEM_WAIT -> next cycle state=RUN, counters=0, mem_err=0. With CNT_W=4, 20 stall cycles -> stall_cnt=15. cnt_clr together with a stall -> 0.
